unpacker: RTL and testbench
===========================

Name: unpacker

Overview:
- Inverse of the pipeline's packing stage: accepts packed BIT_WIDTH-bit rows of reduced-precision data read from memory and emits one full-width value per handshake.
- Sits between the buffer read port and the pipeline input.
- Values are packed LSB-first, contiguous across row boundaries, each i_prec bits wide.
- Output values are zero- or sign-extended to BIT_WIDTH.

Parameters:
- BIT_WIDTH, 16, full-precision value width and packed row width.
- PREC_BITS, 5, width of i_prec; must hold BIT_WIDTH.
- CNT_BITS, 6, width of the internal bit counter; must hold 2*BIT_WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_row  input  BIT_WIDTH  packed row.
- i_row_valid  input  1  i_row valid.
- o_row_ready  output  1  unpacker can accept a row this cycle.
- i_prec  input  PREC_BITS  value precision, legal 1..BIT_WIDTH.
- i_sign_ext  input  1  1 = sign-extend outputs, 0 = zero-extend.
- i_flush  input  1  discard all buffered bits (end of layer / row padding).
- o_out  output  BIT_WIDTH  unpacked value.
- o_out_valid  output  1  o_out valid.
- i_out_ready  input  1  consumer accepts o_out.

Behaviour:
- State: buffer reg buf[2*BIT_WIDTH-1:0] and bit count cnt (0..2*BIT_WIDTH). Valid bits are buf[cnt-1:0]; the oldest bit is buf[0].
- Reset (async, rst_n low): buf=0, cnt=0. o_out_valid=0. o_row_ready=1 once rst_n is high. o_out=0.
- Effective precision p:
  - p = i_prec if 1 <= i_prec <= BIT_WIDTH, otherwise BIT_WIDTH.
  - i_prec and i_sign_ext must be held stable while cnt != 0; changing them mid-stream is undefined.
- Row handshake:
  - o_row_ready = (cnt <= BIT_WIDTH) && !i_flush.
  - load = i_row_valid && o_row_ready.
- Output handshake:
  - o_out_valid = (cnt >= p) && !i_flush.
  - pop = o_out_valid && i_out_ready.
- Output data: o_out is combinational from registered state. It equals buf[p-1:0], extended to BIT_WIDTH per i_sign_ext using bit p-1. When p=BIT_WIDTH, extension is a no-op.
- Next state (single update per cycle):
  - pop only: buf >>= p; cnt -= p.
  - load only: buf |= i_row << cnt; cnt += BIT_WIDTH.
  - pop and load together: buf = (buf >> p) | (i_row << (cnt-p)); cnt = cnt - p + BIT_WIDTH.
  - Bits above the new cnt must be written to 0 so OR-insertion stays correct.
- Flush: i_flush high forces cnt=0 and buf=0 at the next edge. Flush wins over any simultaneous load or pop; both handshakes are suppressed that cycle.
- Latency: a row accepted at edge N yields its first value on o_out_valid in cycle N+1, provided the stream is aligned. No bubbles while both sides are streaming.
  - For p=BIT_WIDTH: 1 value per cycle sustained.
  - For p<BIT_WIDTH: input is throttled by o_row_ready.
- Full: cnt > BIT_WIDTH deasserts o_row_ready. The buffer can never overflow.
- Empty/partial: when cnt < p, o_out_valid=0. Leftover bits persist until more rows arrive or flush.
- Values straddling a row boundary are assembled from both rows transparently.

Test Plan:
- Reset mid-stream: load 0xFFFF, assert rst_n low asynchronously -> o_out_valid=0 immediately, cnt=0; o_row_ready=1 after release.
- p=16 passthrough: rows 0x1234, 0xABCD back-to-back, i_out_ready=1 -> o_out 0x1234 then 0xABCD on consecutive cycles, one cycle after each load.
- p=8, zero-extend: row 0xBA98 -> 0x0098 then 0x00BA. o_row_ready stays high when the next row is offered with cnt=8.
- p=5 boundary: rows 0xFFFF then 0x0000 -> 0x001F, 0x001F, 0x001F, then 0x0001 (straddles rows), then 0x0000, 0x0000; cnt ends at 2.
  - Then i_flush for 1 cycle -> cnt=0, o_out_valid=0.
- p=4, sign-extend: row 0x7F8F -> 0xFFFF, 0xFFF8, 0xFFFF, 0x0007.
  - Repeat with i_sign_ext=0 -> 0x000F, 0x0008, 0x000F, 0x0007.
- Backpressure: p=3, i_out_ready=0 while offering rows -> exactly 2 rows accepted (cnt=32), o_row_ready=0, o_out stable.
  - Release i_out_ready -> 10 values drain in order; o_row_ready reasserts when cnt <= 16.

Source files
------------

// File: rtl/unpacker.sv
// Unpacks LSB-first, row-contiguous reduced-precision values from BIT_WIDTH-bit rows and emits
// one zero- or sign-extended BIT_WIDTH-bit value per output handshake.
module unpacker #(
  parameter int unsigned BIT_WIDTH = 16,
  parameter int unsigned PREC_BITS = 5,
  parameter int unsigned CNT_BITS  = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BIT_WIDTH-1:0] i_row,
  input  logic                 i_row_valid,
  output logic                 o_row_ready,
  input  logic [PREC_BITS-1:0] i_prec,
  input  logic                 i_sign_ext,
  input  logic                 i_flush,
  output logic [BIT_WIDTH-1:0] o_out,
  output logic                 o_out_valid,
  input  logic                 i_out_ready
);

  localparam int unsigned BufW = 2 * BIT_WIDTH;
  localparam int unsigned IdxW = $clog2(BIT_WIDTH);
  localparam logic [CNT_BITS-1:0]  BwCnt  = CNT_BITS'(BIT_WIDTH);
  localparam logic [PREC_BITS-1:0] BwPrec = PREC_BITS'(BIT_WIDTH);

  logic [BufW-1:0]      data_q, data_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [CNT_BITS-1:0]  p;
  logic                 load, pop;
  logic [BIT_WIDTH-1:0] val_raw, val_mask;
  logic [IdxW-1:0]      sign_idx;
  logic                 sign_bit;
  logic [BufW-1:0]      shifted, keep_mask;
  logic [CNT_BITS-1:0]  base_cnt;

  // Out-of-range precision falls back to full width.
  always_comb begin
    if (i_prec != '0 && i_prec <= BwPrec) begin
      p = CNT_BITS'(i_prec);
    end else begin
      p = BwCnt;
    end
  end

  assign o_row_ready = (cnt_q <= BwCnt) && !i_flush;
  assign o_out_valid = (cnt_q >= p) && !i_flush;
  assign load        = i_row_valid && o_row_ready;
  assign pop         = o_out_valid && i_out_ready;

  always_comb begin
    val_raw  = data_q[BIT_WIDTH-1:0];
    val_mask = {BIT_WIDTH{1'b1}} >> (BwCnt - p);
    sign_idx = IdxW'(p - 1'b1);
    sign_bit = i_sign_ext && val_raw[sign_idx];
    o_out    = (val_raw & val_mask) | (sign_bit ? ~val_mask : '0);
  end

  always_comb begin
    shifted  = data_q;
    base_cnt = cnt_q;
    if (pop) begin
      shifted  = data_q >> p;
      base_cnt = cnt_q - p;
    end
    data_d = shifted;
    cnt_d  = base_cnt;
    if (load) begin
      data_d = shifted | ({{BIT_WIDTH{1'b0}}, i_row} << base_cnt);
      cnt_d  = base_cnt + BwCnt;
    end
    // Clear everything above the new count; a count of BufW shifts the 1 out, giving all ones.
    keep_mask = (BufW'(1) << cnt_d) - BufW'(1);
    data_d    = data_d & keep_mask;
    if (i_flush) begin
      data_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_unpacker.sv
// Scoreboard bench for unpacker: a bit-queue reference model predicts every output value,
// a separate monitor compares the DUT output stream against the expected queue.
module tb_unpacker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] i_row;
  logic        i_row_valid;
  logic        o_row_ready;
  logic [4:0]  i_prec;
  logic        i_sign_ext;
  logic        i_flush;
  logic [15:0] o_out;
  logic        o_out_valid;
  logic        i_out_ready;

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;
  int mcnt     = 0;
  bit          bitq[$];
  logic [15:0] expq[$];

  unpacker #(
    .BIT_WIDTH(16),
    .PREC_BITS(5),
    .CNT_BITS (6)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_row      (i_row),
    .i_row_valid(i_row_valid),
    .o_row_ready(o_row_ready),
    .i_prec     (i_prec),
    .i_sign_ext (i_sign_ext),
    .i_flush    (i_flush),
    .o_out      (o_out),
    .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int peff(input int pr);
    return (pr >= 1 && pr <= 16) ? pr : 16;
  endfunction

  // Turn every complete group of p buffered bits into an expected value.
  function automatic void gen();
    int p;
    logic [15:0] v;
    p = peff(int'(i_prec));
    while (bitq.size() >= p) begin
      v = '0;
      for (int k = 0; k < p; k++) v[k] = bitq.pop_front();
      if (i_sign_ext && v[p-1]) for (int k = p; k < 16; k++) v[k] = 1'b1;
      expq.push_back(v);
    end
  endfunction

  function automatic void model_clear();
    mcnt = 0;
    bitq.delete();
    expq.delete();
  endfunction

  // One clock of stimulus; handshake flags and bit count come from the model.
  task automatic step(input logic rv, input logic [15:0] row, input logic ordy, input logic fl);
    int p;
    logic exp_rdy, exp_vld;
    i_row_valid = rv;
    i_row       = row;
    i_out_ready = ordy;
    i_flush     = fl;
    @(negedge clk);
    p       = peff(int'(i_prec));
    exp_rdy = (mcnt <= 16) && !fl;
    exp_vld = (mcnt >= p) && !fl;
    check("row_ready", 32'(o_row_ready), 32'(exp_rdy));
    check("out_valid", 32'(o_out_valid), 32'(exp_vld));
    check("bit_count", 32'(dut.cnt_q), mcnt);
    if (fl) begin
      model_clear();
    end else begin
      if (exp_vld && ordy) mcnt -= p;
      if (rv && exp_rdy) begin
        mcnt += 16;
        for (int k = 0; k < 16; k++) bitq.push_back(row[k]);
        gen();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b1, 1'b0);
  endtask

  // Monitor: every presented value must match the queue head; it is consumed only on handshake.
  always @(negedge clk) begin
    if (rst_n && o_out_valid) begin
      if (expq.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL out_unexpected: got %h expected no output at %0t", o_out, $time);
      end else begin
        check("out_data", 32'(o_out), 32'(expq[0]));
        if (i_out_ready) begin
          void'(expq.pop_front());
          n_out++;
        end
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    i_row       = '0;
    i_row_valid = 1'b0;
    i_prec      = 5'd16;
    i_sign_ext  = 1'b0;
    i_flush     = 1'b0;
    i_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out", 32'(o_out), 32'h0);
    check("reset_valid", 32'(o_out_valid), 32'h0);
    check("reset_row_ready", 32'(o_row_ready), 32'h1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a stream.
    step(1'b1, 16'hFFFF, 1'b0, 1'b0);
    i_row_valid = 1'b0;
    rst_n       = 1'b0;
    #1;
    check("async_rst_valid", 32'(o_out_valid), 32'h0);
    check("async_rst_cnt", 32'(dut.cnt_q), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Full-width passthrough.
    step(1'b1, 16'h1234, 1'b1, 1'b0);
    step(1'b1, 16'hABCD, 1'b1, 1'b0);
    idle(2);

    // p=8 zero-extend; second row offered with 8 bits still buffered.
    i_prec = 5'd8;
    step(1'b1, 16'hBA98, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b1, 16'h1357, 1'b1, 1'b0);
    idle(3);

    // p=5 across a row boundary, leaving 2 bits, then flush.
    i_prec = 5'd5;
    step(1'b1, 16'hFFFF, 1'b1, 1'b0);
    step(1'b1, 16'h0000, 1'b1, 1'b0);
    idle(8);
    check("p5_leftover", 32'(mcnt), 32'd2);
    step(1'b0, 16'h0000, 1'b1, 1'b1);
    idle(1);

    // p=4 sign-extend, then zero-extend on the same row.
    i_prec     = 5'd4;
    i_sign_ext = 1'b1;
    step(1'b1, 16'h7F8F, 1'b1, 1'b0);
    idle(5);
    i_sign_ext = 1'b0;
    step(1'b1, 16'h7F8F, 1'b1, 1'b0);
    idle(5);

    // p=3 backpressure: only two rows fit, then drain.
    i_prec = 5'd3;
    for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
    check("bp_full", 32'(mcnt), 32'd32);
    idle(12);
    step(1'b0, 16'h0000, 1'b1, 1'b1);

    // Randomized phases; precision and extension only change while the buffer is empty.
    for (int ph = 0; ph < 10; ph++) begin
      i_prec     = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(1, 16))
                                               : 5'($urandom_range(0, 31));
      i_sign_ext = 1'($urandom_range(0, 1));
      for (int i = 0; i < 150; i++) begin
        step(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 49) == 0));
      end
      step(1'b0, 16'h0000, 1'b1, 1'b1);
    end
    idle(2);

    check("expq_drained", 32'(expq.size()), 32'd0);
    n_checks++;
    if (n_out < 200) begin
      n_errors++;
      $display("FAIL out_count: got %0d values expected at least 200", n_out);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
